// File: rtl/serialize_word_to_bit_stream_pkg.sv
// Shared types for the serial datapath: the serializer FSM states and the
// downstream sequence-detector FSM states, kept together so both ends of the
// bit stream agree on naming.
package serialize_word_to_bit_stream_pkg;

   // Serializer control states
   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_t;

   // Downstream sequence-detector states (consumer of the serial bit a)
   typedef enum logic [2:0] {
      DET_IDLE = 3'd0,
      DET_S1   = 3'd1,
      DET_S2   = 3'd2,
      DET_S3   = 3'd3,
      DET_HIT  = 3'd4
   } det_state_t;

   // Counter width for a W-bit word (never narrower than 1 bit)
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial converter with a valid/ready word input.
// A word accepted on edge t puts send-order bit k on a in cycle t+1+k.
// At the final bit the block is ready again, so a continuously valid
// upstream gets a gap-free bit stream.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous reset, active low
//   in_valid  word present on in_data
//   in_ready  word on in_data is taken this cycle (if in_valid)
//   in_data   W-bit parallel word
//   a         serial data bit (goes straight to the detector input)
//   a_valid   a carries a data bit
//   last      a is the final bit of its word
//
// Parameters
//   W          word width, 2..32
//   MSB_FIRST  1: bit W-1 first, 0: bit 0 first
module serialize_word_to_bit_stream
   import serialize_word_to_bit_stream_pkg::*;
#(
   parameter int unsigned W         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         a,
   output logic         a_valid,
   output logic         last
);

   localparam int unsigned CW = cnt_width(W);
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   ser_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sr_q, sr_d;

   logic          at_last;
   logic          accept;
   logic [W-1:0]  sr_shifted;

   assign at_last  = (cnt_q == LAST_CNT);
   assign in_ready = (state_q == SER_IDLE) || at_last;
   assign accept   = in_valid && in_ready;

   // The outgoing bit always sits at the send end of the register, so the
   // next bit is exposed by shifting away from that end.
   always_comb begin
      if (MSB_FIRST) sr_shifted = {sr_q[W-2:0], 1'b0};
      else           sr_shifted = {1'b0, sr_q[W-1:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      unique case (state_q)
         SER_IDLE: begin
            if (accept) begin
               state_d = SER_SHIFT;
               cnt_d   = '0;
               sr_d    = in_data;
            end
         end
         SER_SHIFT: begin
            if (!at_last) begin
               cnt_d = cnt_q + 1'b1;
               sr_d  = sr_shifted;
            end else if (accept) begin
               // back-to-back: next word starts without an idle bit
               cnt_d = '0;
               sr_d  = in_data;
            end else begin
               state_d = SER_IDLE;
               cnt_d   = '0;
               sr_d    = '0;
            end
         end
         default: begin
            state_d = SER_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   // Outputs depend on state and the shift register only, never on in_*.
   assign a_valid = (state_q == SER_SHIFT);
   assign a       = a_valid && (MSB_FIRST ? sr_q[W-1] : sr_q[0]);
   assign last    = a_valid && at_last;

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Three serializer instances (W8 MSB-first, W8 LSB-first, W6 MSB-first) share
// in_valid/in_data and are each checked every cycle against a queue model:
// the queue holds the bits still to appear on a, front = current bit.
module tb_serialize_word_to_bit_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic [5:0] din6;
   logic [2:0] rdy, av, aa, ll;

   int checks   = 0;
   int failures = 0;

   localparam int WD[3] = '{8, 8, 6};
   localparam bit MF[3] = '{1'b1, 1'b0, 1'b1};

   bit mq[3][$];

   assign din6 = din[5:0];

   always #5 clk = ~clk;

   serialize_word_to_bit_stream #(.W(8), .MSB_FIRST(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(din), .a(aa[0]), .a_valid(av[0]), .last(ll[0]));
   serialize_word_to_bit_stream #(.W(8), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(din), .a(aa[1]), .a_valid(av[1]), .last(ll[1]));
   serialize_word_to_bit_stream #(.W(6), .MSB_FIRST(1'b1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(din6), .a(aa[2]), .a_valid(av[2]), .last(ll[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the reference: current bit leaves, accepted word queues up.
   task automatic model_edge(input bit v, input logic [7:0] d);
      for (int i = 0; i < 3; i++) begin
         bit acc;
         acc = v && (mq[i].size() <= 1);
         if (mq[i].size() > 0) void'(mq[i].pop_front());
         if (acc)
            for (int k = 0; k < WD[i]; k++)
               mq[i].push_back(d[MF[i] ? (WD[i] - 1 - k) : k]);
      end
   endtask

   task automatic check_outs(input string ph);
      for (int i = 0; i < 3; i++) begin
         int n;
         n = mq[i].size();
         chk($sformatf("%s.av%0d", ph, i), 32'(av[i]),  32'(n > 0));
         chk($sformatf("%s.a%0d",  ph, i), 32'(aa[i]),  32'(n > 0 ? mq[i][0] : 1'b0));
         chk($sformatf("%s.last%0d", ph, i), 32'(ll[i]), 32'(n == 1));
         chk($sformatf("%s.rdy%0d", ph, i), 32'(rdy[i]), 32'(n <= 1));
      end
   endtask

   // Called at a falling edge: drive inputs, take the rising edge, check.
   task automatic cyc(input string ph, input bit v, input logic [7:0] d);
      in_valid = v;
      din      = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      check_outs(ph);
      @(negedge clk);
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock.
   task automatic pulse_reset(input string ph);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         chk($sformatf("%s.rst_av%0d", ph, i), 32'(av[i]), 32'd0);
         chk($sformatf("%s.rst_a%0d",  ph, i), 32'(aa[i]), 32'd0);
         chk($sformatf("%s.rst_l%0d",  ph, i), 32'(ll[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      check_outs({ph, ".hold"});
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      pulse_reset("por");
      // first acceptance on the first edge after release
      cyc("w33", 1'b1, 8'h33);
      for (int k = 0; k < 8; k++) cyc("w33", 1'b0, 8'h00);
      // single word, LSB-first instance expects 1,0,1,0,0,1,0,1
      cyc("a5", 1'b1, 8'hA5);
      for (int k = 0; k < 9; k++) cyc("a5", 1'b0, $urandom);
      // sustained valid, two words back-to-back
      cyc("f0", 1'b1, 8'hF0);
      for (int k = 0; k < 7; k++) cyc("f0", 1'b1, 8'hF0);
      for (int k = 0; k < 8; k++) cyc("0f", 1'b1, 8'h0F);
      for (int k = 0; k < 10; k++) cyc("drain", 1'b0, 8'h00);
      // in_data changes mid-word with in_valid low
      cyc("c3", 1'b1, 8'hC3);
      for (int k = 0; k < 9; k++) cyc("c3", 1'b0, 8'h00);
      // reset in the middle of a word: nothing left over afterwards
      cyc("ff", 1'b1, 8'hFF);
      for (int k = 0; k < 3; k++) cyc("ff", 1'b0, 8'h00);
      pulse_reset("mid");
      for (int k = 0; k < 5; k++) cyc("post", 1'b0, $urandom);
      // randomized traffic
      for (int k = 0; k < 400; k++)
         cyc("rnd", ($urandom_range(0, 3) != 0), 8'($urandom));
      for (int k = 0; k < 10; k++) cyc("end", 1'b0, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
